sdram_bus_arbiter: RTL and testbench
====================================

// Module: sdram_bus_arbiter
// PURPOSE
//  Two-master arbiter in front of the SDRAM controller host interface.
//  Merges the instruction fetch bus (read-only) and the data bus (read/write)
//  into one stream of single-word SDRAM transactions.
//  Issues one transaction at a time: one-cycle cs pulse, then waits for h_compl.
//  Routes the read data and an ack pulse back to the requesting master.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  cycles to wait for h_compl before abort (SDRAM_ARB_TIMEOUT_EN only)
// PORTS
//  clk            in   1     system clock
//  rst_n          in   1     asynchronous active-low reset
//  i_req          in   1     ifetch request; held until i_ack
//  i_addr         in   30    ifetch word address [31:2]
//  i_ack          out  1     one-cycle completion pulse; i_rdata valid this cycle
//  i_rdata        out  32    ifetch read data
//  d_req          in   1     data request; held until d_ack
//  d_addr         in   30    data word address [31:2]
//  d_wdata        in   32    write data
//  d_wr_en        in   1     1=write, 0=read
//  d_bytesel      in   4     byte enables (bit n -> byte n)
//  d_ack          out  1     one-cycle completion pulse; d_rdata valid this cycle
//  d_rdata        out  32    data read data
//  d_err          out  1     one-cycle abort pulse (SDRAM_ARB_TIMEOUT_EN only, else tied 0)
//  cs             out  1     one-cycle transaction strobe to controller
//  h_addr         out  30    controller word address
//  h_wdata        out  32    controller write data
//  h_wr_en        out  1     controller write enable
//  h_bytesel      out  4     controller byte enables
//  h_rdata        in   32    controller read data; valid with h_compl
//  h_compl        in   1     controller completion pulse
//  h_config_done  in   1     controller init complete; no cs before this is 1
// BEHAVIOUR
//  Reset: all outputs 0.
//  Reset: state=WAIT_CFG, last_grant=I, so D wins the first tie.
//  All outputs are registered.
//  FSM:
//   WAIT_CFG    -> IDLE when h_config_done==1.
//   IDLE        -> ISSUE when any req is high.
//     Latch the winner's addr/wdata/wr_en/bytesel into h_*.
//     Ifetch transactions drive h_wr_en=0, h_bytesel=4'b1111, h_wdata=0.
//   ISSUE       -> WAIT_COMPL: cs=1 for exactly this one cycle.
//   WAIT_COMPL  -> IDLE on h_compl.
//     On that edge, capture h_rdata into the owner's *_rdata.
//     Pulse the owner's *_ack on the next cycle.
//  h_* outputs hold stable from ISSUE until h_compl.
//  Arbitration: round-robin. Both req high in IDLE -> grant goes to the master
//   that was not granted last. Single req high -> that master wins.
//  Latency: req high at edge N -> cs high in cycle N+1. With h_compl at N+2,
//   ack at N+3. Back-to-back throughput: one transaction per 4 cycles.
//  Write acks also return *_rdata=0. Write data is not echoed.
//  *_rdata holds its value between acks.
//  Grant is sampled only in IDLE. A req that drops before ack is ignored once
//   granted: the transaction still completes and still acks.
//  h_compl outside WAIT_COMPL is ignored.
//  h_config_done is checked only in WAIT_CFG. Once left, WAIT_CFG is entered
//   again only via reset.
//  Reset mid-transaction: FSM returns to WAIT_CFG. No ack is produced. Any
//   controller completion that arrives afterwards is discarded.
// CONFIGURATION
//  SDRAM_ARB_TIMEOUT_EN defined:
//   - A counter runs in WAIT_COMPL.
//   - After TIMEOUT_CYCLES cycles without h_compl, the FSM goes to IDLE.
//   - The owner gets a one-cycle *_ack together with d_err=1 (data owner).
//     The instruction owner gets i_ack with i_rdata=32'hFFFFFFFF.
//   - A late h_compl after a timeout is ignored.
//  SDRAM_ARB_TIMEOUT_EN undefined:
//   - WAIT_COMPL waits forever.
//   - d_err is tied 0 and the counter is absent.
// TESTING
//  1. h_config_done=0 for 20 cycles while d_req=1 -> cs stays 0 throughout;
//     after config_done rises, exactly one cs pulse.
//  2. d write addr=30'h10, wdata=32'hDEADBEEF, bytesel=4'b0101 -> cs held 1 cycle
//     with h_* matching; then d read of 30'h10 -> d_rdata=32'h00AD00EF
//     (model memory zeroed).
//  3. i_req and d_req both held high for 6 transactions -> grants alternate
//     D,I,D,I,D,I; each ack is 3 cycles after its cs.
//  4. i_req for 30'h20 with the model returning h_compl 5 cycles late -> h_addr
//     stable throughout, i_ack once, d_ack never asserted.
//  5. rst_n pulled low in WAIT_COMPL -> all outputs 0 immediately; no ack after
//     release; the first cs comes only after h_config_done.
//  6. (SDRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8) h_compl never asserted on a
//     d read -> d_ack and d_err both pulse 8 cycles after cs; the next request
//     is serviced normally.

Source files
------------

// File: rtl/sdram_bus_arbiter.sv
// rtl/sdram_bus_arbiter.sv - round-robin ifetch/data arbiter in front of the SDRAM controller host port
// Optional completion timeout with abort pulse: define SDRAM_ARB_TIMEOUT_EN.
module sdram_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [29:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_wr_en,
  input  logic [3:0]  d_bytesel,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        cs,
  output logic [29:0] h_addr,
  output logic [31:0] h_wdata,
  output logic        h_wr_en,
  output logic [3:0]  h_bytesel,
  input  logic [31:0] h_rdata,
  input  logic        h_compl,
  input  logic        h_config_done
);

  typedef enum logic [1:0] {WAIT_CFG, IDLE, ISSUE, WAIT_COMPL} state_t;

  state_t      state, state_nxt;
  logic        last_d, last_d_nxt;
  logic        own_d, own_d_nxt;
  logic        cs_nxt, i_ack_nxt, d_ack_nxt, h_wr_en_nxt;
  logic [29:0] h_addr_nxt;
  logic [31:0] h_wdata_nxt, i_rdata_nxt, d_rdata_nxt;
  logic [3:0]  h_bytesel_nxt;
  logic        grant_d, start;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
  logic          d_err_q, d_err_nxt;
  assign d_err = d_err_q;
`else
  assign d_err = 1'b0;
`endif

  // D wins unless I is also requesting and D had the previous grant.
  assign grant_d = d_req & (~i_req | ~last_d);
  // No new grant during an ack cycle: the acked master still holds req there.
  assign start   = (i_req | d_req) & ~i_ack & ~d_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_CFG;
      last_d    <= 1'b0;
      own_d     <= 1'b0;
      cs        <= 1'b0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      h_addr    <= '0;
      h_wdata   <= '0;
      h_wr_en   <= 1'b0;
      h_bytesel <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
      d_err_q   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      last_d    <= last_d_nxt;
      own_d     <= own_d_nxt;
      cs        <= cs_nxt;
      i_ack     <= i_ack_nxt;
      d_ack     <= d_ack_nxt;
      i_rdata   <= i_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      h_addr    <= h_addr_nxt;
      h_wdata   <= h_wdata_nxt;
      h_wr_en   <= h_wr_en_nxt;
      h_bytesel <= h_bytesel_nxt;
`ifdef SDRAM_ARB_TIMEOUT_EN
      tmo_cnt   <= tmo_cnt_nxt;
      d_err_q   <= d_err_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    last_d_nxt    = last_d;
    own_d_nxt     = own_d;
    cs_nxt        = 1'b0;
    i_ack_nxt     = 1'b0;
    d_ack_nxt     = 1'b0;
    i_rdata_nxt   = i_rdata;
    d_rdata_nxt   = d_rdata;
    h_addr_nxt    = h_addr;
    h_wdata_nxt   = h_wdata;
    h_wr_en_nxt   = h_wr_en;
    h_bytesel_nxt = h_bytesel;
`ifdef SDRAM_ARB_TIMEOUT_EN
    tmo_cnt_nxt   = '0;
    d_err_nxt     = 1'b0;
`endif
    unique case (state)
      WAIT_CFG: begin
        if (h_config_done) state_nxt = IDLE;
      end
      IDLE: begin
        if (start) begin
          state_nxt  = ISSUE;
          cs_nxt     = 1'b1;
          own_d_nxt  = grant_d;
          last_d_nxt = grant_d;
          if (grant_d) begin
            h_addr_nxt    = d_addr;
            h_wdata_nxt   = d_wdata;
            h_wr_en_nxt   = d_wr_en;
            h_bytesel_nxt = d_bytesel;
          end else begin
            h_addr_nxt    = i_addr;
            h_wdata_nxt   = '0;
            h_wr_en_nxt   = 1'b0;
            h_bytesel_nxt = 4'b1111;
          end
        end
      end
      ISSUE: begin
        state_nxt = WAIT_COMPL;
`ifdef SDRAM_ARB_TIMEOUT_EN
        // The cs cycle counts, so the abort ack lands TIMEOUT_CYCLES after cs.
        tmo_cnt_nxt = TW'(1);
`endif
      end
      WAIT_COMPL: begin
        if (h_compl) begin
          state_nxt = IDLE;
          if (own_d) begin
            d_ack_nxt   = 1'b1;
            d_rdata_nxt = h_wr_en ? 32'h0 : h_rdata;
          end else begin
            i_ack_nxt   = 1'b1;
            i_rdata_nxt = h_rdata;
          end
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          state_nxt = IDLE;
          if (own_d) begin
            d_ack_nxt   = 1'b1;
            d_err_nxt   = 1'b1;
            d_rdata_nxt = 32'h0;
          end else begin
            i_ack_nxt   = 1'b1;
            i_rdata_nxt = 32'hFFFF_FFFF;
          end
        end else begin
          tmo_cnt_nxt = tmo_cnt + 1'b1;
        end
`endif
      end
      default: state_nxt = WAIT_CFG;
    endcase
  end

endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// tb/tb_sdram_bus_arbiter.sv - scoreboard bench for sdram_bus_arbiter with a behavioural controller model
module tb_sdram_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [29:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic [29:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_wr_en = 1'b0;
  logic [3:0]  d_bytesel = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        cs;
  logic [29:0] h_addr;
  logic [31:0] h_wdata;
  logic        h_wr_en;
  logic [3:0]  h_bytesel;
  logic [31:0] h_rdata = '0;
  logic        h_compl = 1'b0;
  logic        h_config_done = 1'b0;

  sdram_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wr_en(d_wr_en),
    .d_bytesel(d_bytesel), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .cs(cs), .h_addr(h_addr), .h_wdata(h_wdata), .h_wr_en(h_wr_en),
    .h_bytesel(h_bytesel), .h_rdata(h_rdata), .h_compl(h_compl),
    .h_config_done(h_config_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [29:0] addr; logic [31:0] wdata; logic wr; logic [3:0] bsel;} cs_t;
  typedef struct packed {logic [31:0] rdata; logic err; logic [7:0] lat;} ack_t;

  cs_t  cs_q[$];
  ack_t i_q[$];
  ack_t d_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   cs_count = 0;
  int   comp_delay = 2;
  logic [31:0] mem [logic [29:0]];

  logic [134:0] outs;
  assign outs = {i_ack, i_rdata, d_ack, d_rdata, d_err, cs, h_addr, h_wdata, h_wr_en, h_bytesel};

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: h_compl comes comp_delay cycles after the cs cycle (0 = never).
  initial begin
    int          m_cnt;
    logic [29:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_wr;
    logic [3:0]  m_bsel;
    m_cnt = 0;
    forever begin
      @(negedge clk);
      h_compl = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          if (m_wr) begin
            logic [31:0] w;
            w = mem.exists(m_addr) ? mem[m_addr] : 32'h0;
            for (int b = 0; b < 4; b++)
              if (m_bsel[b]) w[b*8 +: 8] = m_wdata[b*8 +: 8];
            mem[m_addr] = w;
            h_rdata = 32'h5A5A_5A5A;
          end else begin
            h_rdata = mem.exists(m_addr) ? mem[m_addr] : 32'h0;
          end
          h_compl = 1'b1;
        end
      end
      if (cs) begin
        m_cnt   = comp_delay;
        m_addr  = h_addr;
        m_wdata = h_wdata;
        m_wr    = h_wr_en;
        m_bsel  = h_bytesel;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents cs or an ack.
  initial begin
    cs_t  cur, fl, e;
    ack_t a;
    logic fl_v;
    int   cs_cyc, stable_bad, lat;
    fl_v = 1'b0;
    cs_cyc = 0;
    stable_bad = 0;
    forever begin
      @(negedge clk);
      cur = {h_addr, h_wdata, h_wr_en, h_bytesel};
      if (!rst_n) fl_v = 1'b0;
      else begin
        if (fl_v && cur != fl) stable_bad++;
        if (cs) begin
          cs_count++;
          total++;
          if (cs_q.size() == 0) begin
            bad++;
            $display("FAIL cs_unexpected: got cs addr=%h want no cs", h_addr);
          end else begin
            e = cs_q.pop_front();
            if (cur != e) begin
              bad++;
              $display("FAIL cs_fields: got=%h want=%h", cur, e);
            end
          end
          fl = cur;
          fl_v = 1'b1;
          cs_cyc = cyc;
          stable_bad = 0;
        end
        if (i_ack) begin
          total++;
          lat = cyc - cs_cyc;
          if (i_q.size() == 0) begin
            bad++;
            $display("FAIL i_ack_unexpected: got i_ack rdata=%h want none", i_rdata);
          end else begin
            a = i_q.pop_front();
            if (i_rdata != a.rdata || lat != int'(a.lat) || stable_bad != 0) begin
              bad++;
              $display("FAIL i_ack: got rdata=%h lat=%0d unstable=%0d want rdata=%h lat=%0d unstable=0",
                       i_rdata, lat, stable_bad, a.rdata, a.lat);
            end
          end
          fl_v = 1'b0;
        end
        if (d_ack) begin
          total++;
          lat = cyc - cs_cyc;
          if (d_q.size() == 0) begin
            bad++;
            $display("FAIL d_ack_unexpected: got d_ack rdata=%h want none", d_rdata);
          end else begin
            a = d_q.pop_front();
            if ((!a.err && d_rdata != a.rdata) || d_err != a.err || lat != int'(a.lat) || stable_bad != 0) begin
              bad++;
              $display("FAIL d_ack: got rdata=%h err=%b lat=%0d unstable=%0d want rdata=%h err=%b lat=%0d unstable=0",
                       d_rdata, d_err, lat, stable_bad, a.rdata, a.err, a.lat);
            end
          end
          fl_v = 1'b0;
        end
        if (d_err && !d_ack) begin
          total++;
          bad++;
          $display("FAIL d_err_alone: got d_err=1 d_ack=0 want d_err only with d_ack");
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic cfg);
    @(negedge clk);
    rst_n = 1'b0;
    h_config_done = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    cs_q.delete();
    i_q.delete();
    d_q.delete();
    #1 chk("reset_outs", 160'(outs), 160'h0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    h_config_done = cfg;
  endtask

  task automatic wait_ack(input logic is_d);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (is_d ? d_ack : i_ack) begin
        got = 1'b1;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL ack_timeout: got no ack want %s_ack within 100 cycles", is_d ? "d" : "i");
    end
  endtask

  task automatic d_txn(input logic [29:0] a, input logic [31:0] wd, input logic wr, input logic [3:0] bs,
                       input logic [31:0] rd, input logic err, input int lat);
    @(negedge clk);
    d_addr = a; d_wdata = wd; d_wr_en = wr; d_bytesel = bs;
    cs_q.push_back(cs_t'{a, wd, wr, bs});
    d_q.push_back(ack_t'{rd, err, 8'(lat)});
    d_req = 1'b1;
    wait_ack(1'b1);
    d_req = 1'b0;
  endtask

  task automatic i_txn(input logic [29:0] a, input logic [31:0] rd, input int lat);
    @(negedge clk);
    i_addr = a;
    cs_q.push_back(cs_t'{a, 32'h0, 1'b0, 4'hF});
    i_q.push_back(ack_t'{rd, 1'b0, 8'(lat)});
    i_req = 1'b1;
    wait_ack(1'b0);
    i_req = 1'b0;
  endtask

  initial begin
    int snap, nacks;
    mem[30'h020] = 32'hCAFE_0020;
    mem[30'h030] = 32'h3030_3030;
    mem[30'h040] = 32'h4040_4040;
    mem[30'h100] = 32'h1111_0000;
    mem[30'h200] = 32'h2222_0000;

    // no cs while the controller is still initialising
    do_reset(1'b0);
    d_addr = 30'h40; d_wdata = 32'h0; d_wr_en = 1'b0; d_bytesel = 4'hF;
    d_req = 1'b1;
    snap = cs_count;
    tick(20);
    chk("no_cs_before_cfg", 160'(cs_count), 160'(snap));
    cs_q.push_back(cs_t'{30'h40, 32'h0, 1'b0, 4'hF});
    d_q.push_back(ack_t'{32'h4040_4040, 1'b0, 8'd3});
    h_config_done = 1'b1;
    wait_ack(1'b1);
    d_req = 1'b0;
    tick(6);
    chk("one_cs_after_cfg", 160'(cs_count), 160'(snap + 1));

    // byte-masked write then read-back
    d_txn(30'h10, 32'hDEAD_BEEF, 1'b1, 4'b0101, 32'h0, 1'b0, 3);
    d_txn(30'h10, 32'h0, 1'b0, 4'hF, 32'h00AD_00EF, 1'b0, 3);

    // round-robin with both masters holding req
    do_reset(1'b1);
    tick(2);
    i_addr = 30'h100;
    d_addr = 30'h200; d_wdata = 32'h0; d_wr_en = 1'b0; d_bytesel = 4'hF;
    for (int k = 0; k < 3; k++) begin
      cs_q.push_back(cs_t'{30'h200, 32'h0, 1'b0, 4'hF});
      cs_q.push_back(cs_t'{30'h100, 32'h0, 1'b0, 4'hF});
      d_q.push_back(ack_t'{32'h2222_0000, 1'b0, 8'd3});
      i_q.push_back(ack_t'{32'h1111_0000, 1'b0, 8'd3});
    end
    i_req = 1'b1;
    d_req = 1'b1;
    nacks = 0;
    for (int n = 0; n < 200 && nacks < 6; n++) begin
      @(negedge clk);
      if (i_ack) nacks++;
      if (d_ack) nacks++;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk("rr_ack_count", 160'(nacks), 160'd6);
    tick(4);
    chk("rr_cs_drained", 160'(cs_q.size()), 160'd0);

    // late completion on an ifetch
    comp_delay = 7;
    i_txn(30'h20, 32'hCAFE_0020, 8);
    comp_delay = 2;

    // reset while waiting for completion; the stale completion must be dropped
    comp_delay = 6;
    @(negedge clk);
    d_addr = 30'h30; d_wdata = 32'h0; d_wr_en = 1'b0; d_bytesel = 4'hF;
    cs_q.push_back(cs_t'{30'h30, 32'h0, 1'b0, 4'hF});
    d_q.push_back(ack_t'{32'h3030_3030, 1'b0, 8'd7});
    d_req = 1'b1;
    for (int n = 0; n < 50 && !cs; n++) @(negedge clk);
    tick(1);
    rst_n = 1'b0;
    h_config_done = 1'b0;
    d_q.delete();
    #1 chk("reset_mid_txn_outs", 160'(outs), 160'h0);
    @(negedge clk);
    rst_n = 1'b1;
    comp_delay = 2;
    snap = cs_count;
    tick(8);
    chk("no_cs_after_reset", 160'(cs_count), 160'(snap));
    cs_q.push_back(cs_t'{30'h30, 32'h0, 1'b0, 4'hF});
    d_q.push_back(ack_t'{32'h3030_3030, 1'b0, 8'd3});
    h_config_done = 1'b1;
    wait_ack(1'b1);
    d_req = 1'b0;

`ifdef SDRAM_ARB_TIMEOUT_EN
    // missing completion aborts after TIMEOUT_CYCLES
    comp_delay = 0;
    d_txn(30'h50, 32'h0, 1'b0, 4'hF, 32'h0, 1'b1, 8);
    comp_delay = 2;
    d_txn(30'h30, 32'h0, 1'b0, 4'hF, 32'h3030_3030, 1'b0, 3);
`endif

    tick(6);
    chk("end_cs_q_empty", 160'(cs_q.size()), 160'd0);
    chk("end_i_q_empty", 160'(i_q.size()), 160'd0);
    chk("end_d_q_empty", 160'(d_q.size()), 160'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before 2000000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
